// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared ALU.
// Ports: clk, rst_n (sync, active-low); req/op/a/b per requester in;
//   done0/done1/res/err/busy out; alu_alus/alu_x/alu_bus to ALU, alu_dout from ALU.
module alu_arbiter #(
    parameter int DW = 8,
    parameter int OPW = 4,
    parameter logic [OPW-1:0] MAX_OP = 4'd10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0,
    input  logic [OPW-1:0] op0,
    input  logic [DW-1:0]  a0,
    input  logic [DW-1:0]  b0,
    input  logic           req1,
    input  logic [OPW-1:0] op1,
    input  logic [DW-1:0]  a1,
    input  logic [DW-1:0]  b1,
    output logic           done0,
    output logic           done1,
    output logic [DW-1:0]  res,
    output logic           err,
    output logic           busy,
    output logic [OPW-1:0] alu_alus,
    output logic [DW-1:0]  alu_x,
    output logic [DW-1:0]  alu_bus,
    input  logic [DW-1:0]  alu_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state, state_n;
    logic           rr_ptr, rr_n;
    logic           gid, gid_n;
    logic           ill, ill_n;
    logic [OPW-1:0] alus_n;
    logic [DW-1:0]  x_n, bus_n, res_n;
    logic           d0_n, d1_n, err_n;

    logic           g0, g1;
    logic [OPW-1:0] op_s;
    logic [DW-1:0]  a_s, b_s;
    logic           op_bad;

    // On contention rr_ptr picks the winner; a lone requester always wins.
    assign g0 = req0 & (~req1 | ~rr_ptr);
    assign g1 = req1 & (~req0 | rr_ptr);

    assign op_s   = g1 ? op1 : op0;
    assign a_s    = g1 ? a1  : a0;
    assign b_s    = g1 ? b1  : b0;
    assign op_bad = (op_s > MAX_OP);

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        gid_n   = gid;
        ill_n   = ill;
        alus_n  = alu_alus;
        x_n     = alu_x;
        bus_n   = alu_bus;
        res_n   = res;
        d0_n    = 1'b0;
        d1_n    = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                alus_n = '0;
                x_n    = '0;
                bus_n  = '0;
                if (g0 | g1) begin
                    // Illegal codes reach the ALU as 0000; result forced to 0 later.
                    alus_n  = op_bad ? '0 : op_s;
                    x_n     = a_s;
                    bus_n   = b_s;
                    ill_n   = op_bad;
                    gid_n   = g1;
                    rr_n    = ~g1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                res_n   = ill ? '0 : alu_dout;
                d0_n    = ~gid;
                d1_n    = gid;
                err_n   = ill;
                state_n = RESP;
            end
            RESP: begin
                alus_n  = '0;
                x_n     = '0;
                bus_n   = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            gid      <= 1'b0;
            ill      <= 1'b0;
            alu_alus <= '0;
            alu_x    <= '0;
            alu_bus  <= '0;
            res      <= '0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_n;
            gid      <= gid_n;
            ill      <= ill_n;
            alu_alus <= alus_n;
            alu_x    <= x_n;
            alu_bus  <= bus_n;
            res      <= res_n;
            done0    <= d0_n;
            done1    <= d1_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the ALU ports.
// Ports: drives all arbiter inputs, models alu_dout from alu_alus/alu_x/alu_bus.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       done0, done1, err, busy;
    logic [7:0] res;
    logic [3:0] alu_alus;
    logic [7:0] alu_x, alu_bus;
    logic [7:0] alu_dout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: only the opcodes exercised here matter.
    always_comb begin
        alu_dout = alu_x;
        case (alu_alus)
            4'd1:  alu_dout = alu_x + alu_bus;
            4'd2:  alu_dout = alu_x - alu_bus;
            4'd5:  alu_dout = alu_x ^ alu_bus;
            4'd8:  alu_dout = ~alu_x;
            4'd9:  alu_dout = alu_x >> 1;
            4'd10: alu_dout = alu_bus;
            default: alu_dout = alu_x;
        endcase
    end

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .res(res), .err(err), .busy(busy),
        .alu_alus(alu_alus), .alu_x(alu_x), .alu_bus(alu_bus),
        .alu_dout(alu_dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve one op from a single requester and check every phase.
    task automatic do_op(input logic who, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] exp_alus,
                         input logic [7:0] exp_res, input logic exp_err);
        if (who) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        step();
        chk("op_exec_alus", {4'h0, alu_alus}, {4'h0, exp_alus});
        chk("op_exec_x", alu_x, a);
        step();
        chk("op_done0", {7'd0, done0}, {7'd0, ~who});
        chk("op_done1", {7'd0, done1}, {7'd0, who});
        chk("op_res", res, exp_res);
        chk("op_err", {7'd0, err}, {7'd0, exp_err});
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk("op_idle_done", {6'd0, done1, done0}, 8'd0);
        chk("op_idle_err", {7'd0, err}, 8'd0);
        chk("op_idle_alus", {4'h0, alu_alus}, 8'd0);
        chk("op_res_hold", res, exp_res);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        do_reset();

        chk("rst_res", res, 8'h00);
        chk("rst_flags", {4'd0, busy, err, done1, done0}, 8'd0);
        chk("rst_alus", {4'h0, alu_alus}, 8'd0);
        chk("rst_x", alu_x, 8'h00);
        chk("rst_bus", alu_bus, 8'h00);

        // Single op from requester 0
        req0 = 1; op0 = 4'b0001; a0 = 8'h3C; b0 = 8'h05;
        step();
        chk("single_busy", {7'd0, busy}, 8'd1);
        chk("single_alus", {4'h0, alu_alus}, 8'h01);
        chk("single_bus", alu_bus, 8'h05);
        chk("single_nodone", {6'd0, done1, done0}, 8'd0);
        step();
        chk("single_done0", {7'd0, done0}, 8'd1);
        chk("single_done1", {7'd0, done1}, 8'd0);
        chk("single_res", res, 8'h41);
        chk("single_err", {7'd0, err}, 8'd0);
        req0 = 0;
        step();
        chk("single_clear", {6'd0, done1, done0}, 8'd0);
        chk("single_idle", {7'd0, busy}, 8'd0);

        // Simultaneous requests straight after reset
        do_reset();
        req0 = 1; op0 = 4'b0010; a0 = 8'h10; b0 = 8'h20;
        req1 = 1; op1 = 4'b0101; a1 = 8'hAA; b1 = 8'h0F;
        step();
        chk("sim_first_alus", {4'h0, alu_alus}, 8'h02);
        step();
        chk("sim_done0", {6'd0, done1, done0}, 8'b01);
        chk("sim_res0", res, 8'hF0);
        req0 = 0;
        step();
        chk("sim_idle", {7'd0, busy}, 8'd0);
        step();
        chk("sim_second_alus", {4'h0, alu_alus}, 8'h05);
        step();
        chk("sim_done1", {6'd0, done1, done0}, 8'b10);
        chk("sim_res1", res, 8'hA5);
        req1 = 0;
        step();

        // Fairness: both held continuously; grants alternate from 0
        req0 = 1; op0 = 4'b0001; a0 = 8'h01; b0 = 8'h01;
        req1 = 1; op1 = 4'b0001; a1 = 8'h10; b1 = 8'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            step();
            chk("fair_done", {6'd0, done1, done0},
                (i % 2 == 0) ? 8'b01 : 8'b10);
            chk("fair_res", res, (i % 2 == 0) ? 8'h02 : 8'h20);
            step();
        end
        req0 = 0;
        req1 = 0;
        step();

        // Wrap, shift, complement, pass
        do_op(1'b0, 4'b0001, 8'hFF, 8'h01, 4'b0001, 8'h00, 1'b0);
        do_op(1'b1, 4'b1001, 8'h81, 8'h00, 4'b1001, 8'h40, 1'b0);
        do_op(1'b0, 4'b1000, 8'h00, 8'h00, 4'b1000, 8'hFF, 1'b0);
        do_op(1'b1, 4'b1010, 8'h12, 8'h5A, 4'b1010, 8'h5A, 1'b0);

        // Illegal opcode
        do_op(1'b1, 4'b1100, 8'h33, 8'h44, 4'b0000, 8'h00, 1'b1);

        // Reset during EXEC discards the op
        req0 = 1; op0 = 4'b0001; a0 = 8'h20; b0 = 8'h03;
        step();
        chk("rexec_busy", {7'd0, busy}, 8'd1);
        rst_n = 0;
        req0 = 0;
        step();
        rst_n = 1;
        chk("rexec_done", {6'd0, done1, done0}, 8'd0);
        chk("rexec_busy0", {7'd0, busy}, 8'd0);
        chk("rexec_res", res, 8'h00);
        chk("rexec_alus", {4'h0, alu_alus}, 8'd0);
        step();
        chk("rexec_nolate", {6'd0, done1, done0}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU (4-bit opcode select, operands x and bus, combinational dout).
- Latches the winning requester's opcode and operands into registers that drive the ALU.
- Captures the ALU result and returns it with a one-cycle done pulse to that requester.
- Sits between the control unit's two ALU users (e.g. main datapath and address/loop counter path) and the single ALU instance.

Parameters:
DW, 8, data width of operands and result (ALU is 8-bit; only 8 is supported)
OPW, 4, opcode width
MAX_OP, 4'd10, highest legal opcode (4'b1010, pass bus); codes above are illegal

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
req0  in  1  requester 0 request
op0  in  4  requester 0 opcode
a0  in  8  requester 0 x operand
b0  in  8  requester 0 bus operand
req1  in  1  requester 1 request
op1  in  4  requester 1 opcode
a1  in  8  requester 1 x operand
b1  in  8  requester 1 bus operand
done0  out  1  one-cycle pulse: requester 0 result valid on res
done1  out  1  one-cycle pulse: requester 1 result valid on res
res  out  8  registered result, held until next capture
err  out  1  pulses with done when the served opcode was illegal
busy  out  1  high in EXEC and RESP
alu_alus  out  4  opcode to ALU (registered)
alu_x  out  8  x operand to ALU (registered)
alu_bus  out  8  bus operand to ALU (registered)
alu_dout  in  8  ALU combinational result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE, rr_ptr=0 (requester 0 has priority).
  - res=0, done0=done1=err=busy=0.
  - alu_alus=4'b0000, alu_x=alu_bus=0.
  - Reset mid-operation discards the pending op; no done is emitted.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If neither req is high, stay; ALU ports hold 4'b0000 and 0.
  - If only one req is high, grant it.
  - If both are high, grant the requester indicated by rr_ptr.
  - On grant at edge E0: latch op/a/b into the ALU port registers, record grant id, set rr_ptr to the other requester, and move to EXEC.
- Illegal opcode (op > MAX_OP): alu_alus is driven 4'b0000 and an internal illegal flag is set.
- EXEC (one cycle): ALU inputs are stable, so alu_dout is valid combinationally. At edge E1:
  - res <= alu_dout, or 8'h00 if illegal.
  - done(grant id) <= 1 and err <= illegal.
  - Move to RESP.
- RESP (one cycle): done and err are high for exactly this cycle, and res is valid. At edge E2:
  - done and err clear; ALU ports return to 4'b0000 and 0.
  - Move to IDLE.
- Latency: request sampled at E0, done high in the cycle after E1. Throughput is one op per 3 cycles.
- Handshake: requester holds req, op and operands stable from assertion until it sees its done. It must drop req by edge E2 or the request is re-granted as a new op at E3.
- Requests arriving during EXEC/RESP are not sampled until IDLE. req deasserted before grant is simply ignored (no abort once granted).
- Arithmetic: all results modulo 2^8 (ALU wraps); the arbiter adds no carry or flags.
- rr_ptr changes only on grant. A single continuous requester is served back-to-back every 3 cycles.
- done0 and done1 are never high simultaneously. busy = (state != IDLE).

Test Plan:
- Reset: drive rst_n=0 for 2 cycles, then release -> all outputs 0, alu_alus=0000, busy=0, no done.
- Single op: req0, op0=0001, a0=0x3C, b0=0x05 -> alu_alus=0001 in EXEC; done0 for one cycle two edges after grant with res=0x41; err=0; done1 stays 0.
- Simultaneous after reset: req0 with op0=0010 (0x10-0x20) and req1 with op1=0101 (0xAA^0x0F), both held until their own done.
  - req0 served first: res=0xF0.
  - req1 then granted at the next IDLE: res=0xA5.
- Fairness: req0 held continuously and req1 asserted -> grants alternate 0,1,0,1; neither is starved.
- Wrap and shift: op=0001 with 0xFF+0x01 -> res=0x00; op=1001 with x=0x81 -> res=0x40; op=1000 with x=0x00 -> res=0xFF.
- Illegal and reset: op=1100 -> res=0x00, err pulses with done. Separately, rst_n=0 during EXEC -> no done, state IDLE, res=0.
